// File: rtl/internode_link_credit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : internode_link_credit_pkg
// Brief    : Shared flit width and width helpers for the inter-node link.
// Revision : 1.0 - initial release
// ============================================================================
package internode_link_credit_pkg;

    localparam int FLIT_SIZE = 32;

    typedef logic [FLIT_SIZE-1:0] flit_t;

    // Index width that never collapses to zero for single-entry spaces.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/internode_link_credit_if.sv
`default_nettype none
// ============================================================================
// Module   : internode_link_credit_if
// Brief    : Transmit/receive handshake bundle of the credited inter-node link.
// Revision : 1.0 - initial release
// ============================================================================
interface internode_link_credit_if #(
    parameter int FLIT_SIZE = internode_link_credit_pkg::FLIT_SIZE,
    parameter int NUM_VC    = 2
);
    localparam int VC_W = internode_link_credit_pkg::clog2_min1(NUM_VC);

    logic                        tx_valid;
    logic [VC_W-1:0]             tx_vc;
    logic [FLIT_SIZE-1:0]        tx_data;
    logic                        tx_ready;
    logic [NUM_VC-1:0]           tx_vc_avail;
    logic [NUM_VC-1:0]           rx_valid;
    logic [NUM_VC*FLIT_SIZE-1:0] rx_data;
    logic [NUM_VC-1:0]           rx_pop;
    logic                        err_overflow;
    logic                        err_credit;

    modport master (
        output tx_valid, tx_vc, tx_data, rx_pop,
        input  tx_ready, tx_vc_avail, rx_valid, rx_data, err_overflow, err_credit
    );

    modport slave (
        input  tx_valid, tx_vc, tx_data, rx_pop,
        output tx_ready, tx_vc_avail, rx_valid, rx_data, err_overflow, err_credit
    );

endinterface
`default_nettype wire

// File: rtl/internode_link_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : link_vc_fifo
// Brief    : One virtual-channel receive buffer with count-based full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module link_vc_fifo #(
    parameter int FLIT_SIZE = 32,
    parameter int BUF_DEPTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 wr_en,
    input  wire logic [FLIT_SIZE-1:0] wr_data,
    input  wire logic                 pop,
    output logic      [FLIT_SIZE-1:0] head,
    output logic                      valid,
    output logic                      overflow
);
    localparam int PTR_W = internode_link_credit_pkg::clog2_min1(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(BUF_DEPTH - 1);

    logic [FLIT_SIZE-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;

    // A pop in the same cycle frees the slot, so a full buffer still takes the write.
    assign w_full   = (r_count == CNT_W'(BUF_DEPTH));
    assign w_pop    = pop && (r_count != '0);
    assign w_wr     = wr_en && (!w_full || w_pop);
    assign overflow = wr_en && w_full && !w_pop;
    assign valid    = (r_count != '0);
    assign head     = valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/internode_link_credit.sv
`default_nettype none
// ============================================================================
// Module   : internode_link_credit
// Brief    : Delayed multi-VC link with receive buffers and returned credits.
// Revision : 1.0 - initial release
// ============================================================================
module internode_link_credit #(
    parameter int FLIT_SIZE = internode_link_credit_pkg::FLIT_SIZE,
    parameter int DELAY     = 100,
    parameter int NUM_VC    = 2,
    parameter int BUF_DEPTH = 8
) (
    input wire logic               clk,
    input wire logic               rst_n,
    internode_link_credit_if.slave link
);
    localparam int VC_W    = internode_link_credit_pkg::clog2_min1(NUM_VC);
    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam int VC_SPAN = 1 << VC_W;

    typedef struct packed {
        logic                 valid;
        logic [VC_W-1:0]      vc;
        logic [FLIT_SIZE-1:0] data;
    } stage_t;

    stage_t             r_fpipe [DELAY];
    logic [NUM_VC-1:0]  r_cpipe [DELAY];
    logic               r_run;
    logic               r_err_ovf;
    logic               r_err_crd;
    logic [NUM_VC-1:0]  w_avail;
    logic [NUM_VC-1:0]  w_take;
    logic [NUM_VC-1:0]  w_ret;
    logic [NUM_VC-1:0]  w_wr;
    logic [NUM_VC-1:0]  w_pop;
    logic [NUM_VC-1:0]  w_rx_valid;
    logic [NUM_VC-1:0]  w_ovf;
    logic [NUM_VC-1:0]  w_crd_err;
    logic [VC_SPAN-1:0] w_avail_ext;
    logic               w_ready;
    logic               w_accept;
    stage_t             w_out;

    // r_run keeps tx_ready low during reset and releases it on the first edge after.
    assign w_out    = r_fpipe[DELAY-1];
    assign w_ret    = r_cpipe[DELAY-1];
    assign w_ready  = r_run & w_avail_ext[link.tx_vc];
    assign w_accept = link.tx_valid & w_ready;
    assign w_pop    = link.rx_pop & w_rx_valid;

    assign link.tx_ready     = w_ready;
    assign link.tx_vc_avail  = w_avail;
    assign link.rx_valid     = w_rx_valid;
    assign link.err_overflow = r_err_ovf;
    assign link.err_credit   = r_err_crd;

    generate
        if (VC_SPAN > NUM_VC) begin : g_pad
            assign w_avail_ext = {{(VC_SPAN - NUM_VC){1'b0}}, w_avail};
        end else begin : g_nopad
            assign w_avail_ext = w_avail;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                r_fpipe[i] <= '0;
                r_cpipe[i] <= '0;
            end
            r_run     <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_crd <= 1'b0;
        end else begin
            r_fpipe[0] <= '{valid: w_accept, vc: link.tx_vc, data: link.tx_data};
            r_cpipe[0] <= w_pop;
            for (int i = 1; i < DELAY; i++) begin
                r_fpipe[i] <= r_fpipe[i-1];
                r_cpipe[i] <= r_cpipe[i-1];
            end
            r_run     <= 1'b1;
            r_err_ovf <= r_err_ovf | (|w_ovf);
            r_err_crd <= r_err_crd | (|w_crd_err);
        end
    end

    generate
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            logic [CNT_W-1:0] r_credit;

            assign w_take[v]    = w_accept && (link.tx_vc == VC_W'(v));
            assign w_wr[v]      = w_out.valid && (w_out.vc == VC_W'(v));
            assign w_avail[v]   = (r_credit != '0);
            // A lone return onto a full counter is a protocol error; it saturates.
            assign w_crd_err[v] = w_ret[v] && !w_take[v] && (r_credit == CNT_W'(BUF_DEPTH));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_credit <= CNT_W'(BUF_DEPTH);
                end else if (w_take[v] && !w_ret[v]) begin
                    r_credit <= r_credit - 1'b1;
                end else if (w_ret[v] && !w_take[v] && !w_crd_err[v]) begin
                    r_credit <= r_credit + 1'b1;
                end
            end

            link_vc_fifo #(
                .FLIT_SIZE (FLIT_SIZE),
                .BUF_DEPTH (BUF_DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (w_wr[v]),
                .wr_data  (w_out.data),
                .pop      (link.rx_pop[v]),
                .head     (link.rx_data[v*FLIT_SIZE +: FLIT_SIZE]),
                .valid    (w_rx_valid[v]),
                .overflow (w_ovf[v])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_internode_link_credit.sv
`default_nettype none
// ============================================================================
// Module   : tb_internode_link_credit
// Brief    : Directed self-checking bench for the credited inter-node link.
// Revision : 1.0 - initial release
// ============================================================================
module tb_internode_link_credit;

    localparam int FS = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    internode_link_credit_if #(.FLIT_SIZE(FS), .NUM_VC(2)) link ();

    internode_link_credit #(
        .FLIT_SIZE (FS),
        .DELAY     (4),
        .NUM_VC    (2),
        .BUF_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        link.tx_valid = 1'b0;
        link.tx_vc    = 1'b0;
        link.tx_data  = '0;
        link.rx_pop   = 2'b00;
        tick(2);
        n_checks++; if (link.rx_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rx_valid: got %b expected 00", link.rx_valid); end
        n_checks++; if (link.tx_vc_avail !== 2'b11) begin n_fail++; $display("FAIL rst_vc_avail: got %b expected 11", link.tx_vc_avail); end
        n_checks++; if (link.tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready: got %b expected 0", link.tx_ready); end
        n_checks++; if ({link.err_overflow, link.err_credit} !== 2'b00) begin n_fail++; $display("FAIL rst_errors: got %b expected 00", {link.err_overflow, link.err_credit}); end
        n_checks++; if (link.rx_data !== 64'h0) begin n_fail++; $display("FAIL rst_rx_data: got %h expected 0", link.rx_data); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (link.tx_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_early: got %b expected 0", link.tx_ready); end
        tick();
        n_checks++; if (link.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b expected 1", link.tx_ready); end
        n_checks++; if (dut.g_vc[0].r_credit !== 3'd4 || dut.g_vc[1].r_credit !== 3'd4) begin n_fail++; $display("FAIL rel_credits: got %0d/%0d expected 4/4", dut.g_vc[0].r_credit, dut.g_vc[1].r_credit); end
    endtask

    task automatic test_single();
        link.tx_valid = 1'b1;
        link.tx_vc    = 1'b0;
        link.tx_data  = 32'hA5;
        tick();
        link.tx_valid = 1'b0;
        n_checks++; if (dut.g_vc[0].r_credit !== 3'd3) begin n_fail++; $display("FAIL single_consume: got %0d expected 3", dut.g_vc[0].r_credit); end
        tick(3);
        n_checks++; if (link.rx_valid !== 2'b00) begin n_fail++; $display("FAIL single_early: got %b expected 00", link.rx_valid); end
        tick();
        n_checks++; if (link.rx_valid !== 2'b01) begin n_fail++; $display("FAIL single_arrive: got %b expected 01", link.rx_valid); end
        n_checks++; if (link.rx_data[31:0] !== 32'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", link.rx_data[31:0]); end
        tick();
        link.rx_pop = 2'b01;
        tick();
        link.rx_pop = 2'b00;
        n_checks++; if (link.rx_valid !== 2'b00) begin n_fail++; $display("FAIL single_popped: got %b expected 00", link.rx_valid); end
        tick(3);
        n_checks++; if (dut.g_vc[0].r_credit !== 3'd3) begin n_fail++; $display("FAIL single_credit_early: got %0d expected 3", dut.g_vc[0].r_credit); end
        tick();
        n_checks++; if (dut.g_vc[0].r_credit !== 3'd4) begin n_fail++; $display("FAIL single_credit_back: got %0d expected 4", dut.g_vc[0].r_credit); end
    endtask

    task automatic test_backpressure();
        link.tx_valid = 1'b1;
        link.tx_vc    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            link.tx_data = 32'h10 + i;
            #1;
            n_checks++; if (link.tx_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_ready_%0d: got %b expected %b", i, link.tx_ready, (i < 4)); end
            tick();
        end
        n_checks++; if (link.tx_vc_avail !== 2'b01) begin n_fail++; $display("FAIL bp_vc_avail: got %b expected 01", link.tx_vc_avail); end
        link.tx_valid = 1'b0;
        tick(4);
        n_checks++; if (link.rx_valid !== 2'b10) begin n_fail++; $display("FAIL bp_rx_valid: got %b expected 10", link.rx_valid); end
        link.rx_pop = 2'b10;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (link.rx_data[63:32] !== 32'h10 + k) begin n_fail++; $display("FAIL bp_order_%0d: got %h expected %h", k, link.rx_data[63:32], 32'h10 + k); end
            tick();
        end
        link.rx_pop = 2'b00;
        n_checks++; if (link.rx_valid !== 2'b00) begin n_fail++; $display("FAIL bp_drained: got %b expected 00", link.rx_valid); end
        tick(4);
        n_checks++; if (dut.g_vc[1].r_credit !== 3'd4) begin n_fail++; $display("FAIL bp_credit_back: got %0d expected 4", dut.g_vc[1].r_credit); end
    endtask

    task automatic test_streaming();
        int accepts;
        accepts       = 0;
        link.tx_valid = 1'b1;
        link.tx_vc    = 1'b0;
        link.rx_pop   = 2'b11;
        for (int k = 0; k < 30; k++) begin
            link.tx_data = 32'hC000 + k;
            #1;
            if (link.tx_ready === 1'b1) accepts++;
            tick();
            if (k >= 4 && k <= 7) begin
                n_checks++; if (dut.g_vc[0].u_fifo.r_count !== 3'd1) begin n_fail++; $display("FAIL stream_occ_%0d: got %0d expected 1", k, dut.g_vc[0].u_fifo.r_count); end
            end
            if (k >= 10 && k <= 12) begin
                n_checks++; if (dut.g_vc[0].r_credit !== 3'd1) begin n_fail++; $display("FAIL stream_take_ret_%0d: got %0d expected 1", k, dut.g_vc[0].r_credit); end
            end
            if (k == 13) begin
                n_checks++; if (dut.g_vc[0].r_credit !== 3'd0) begin n_fail++; $display("FAIL stream_empty_credit: got %0d expected 0", dut.g_vc[0].r_credit); end
            end
        end
        link.tx_valid = 1'b0;
        tick(15);
        link.rx_pop = 2'b00;
        n_checks++; if (accepts !== 12) begin n_fail++; $display("FAIL stream_rate: got %0d expected 12", accepts); end
        n_checks++; if ({link.err_overflow, link.err_credit} !== 2'b00) begin n_fail++; $display("FAIL stream_errors: got %b expected 00", {link.err_overflow, link.err_credit}); end
        n_checks++; if (dut.g_vc[0].r_credit !== 3'd4 || dut.g_vc[1].r_credit !== 3'd4) begin n_fail++; $display("FAIL stream_credits: got %0d/%0d expected 4/4", dut.g_vc[0].r_credit, dut.g_vc[1].r_credit); end
        n_checks++; if (link.rx_valid !== 2'b00) begin n_fail++; $display("FAIL stream_drained: got %b expected 00", link.rx_valid); end
    endtask

    task automatic test_midflight_reset();
        link.tx_valid = 1'b1;
        link.tx_vc    = 1'b0;
        link.tx_data  = 32'hBEEF;
        tick(3);
        link.tx_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (link.tx_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b expected 0", link.tx_ready); end
        n_checks++; if (dut.g_vc[0].r_credit !== 3'd4) begin n_fail++; $display("FAIL mid_async_credit: got %0d expected 4", dut.g_vc[0].r_credit); end
        tick(2);
        rst_n = 1'b1;
        tick(8);
        n_checks++; if (link.rx_valid !== 2'b00) begin n_fail++; $display("FAIL mid_delivered: got %b expected 00", link.rx_valid); end
        n_checks++; if (dut.g_vc[0].r_credit !== 3'd4 || dut.g_vc[1].r_credit !== 3'd4) begin n_fail++; $display("FAIL mid_credits: got %0d/%0d expected 4/4", dut.g_vc[0].r_credit, dut.g_vc[1].r_credit); end
        n_checks++; if ({link.err_overflow, link.err_credit} !== 2'b00) begin n_fail++; $display("FAIL mid_errors: got %b expected 00", {link.err_overflow, link.err_credit}); end
        n_checks++; if (link.tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b expected 1", link.tx_ready); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_midflight_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
